warp_issue_arbiter: RTL
=======================

# warp_issue_arbiter

Round-robin issue scheduler between the per-warp instruction-buffer heads of the core frontend and the single decode/issue port. Each cycle it selects one ready, non-stalled warp, pops that warp's buffer head, and holds it in a one-entry output register until downstream accepts it. It also drops a held instruction on a per-warp flush and keeps issue/backpressure counters for perf tracing.

## Interface
Parameters:
- NUM_WARPS, 8, number of warps and instruction-buffer heads
- ARCH_LEN, 32, PC width
- INST_BITS, 64, raw instruction width
- NUM_LANES, 16, thread-mask width
- CNT_BITS, 32, perf counter width
- WID_BITS, $clog2(NUM_WARPS) (local), warp-id width

Ports:
- clock  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- ibuf_valid  in  NUM_WARPS  per-warp buffer head valid
- ibuf_ready  out  NUM_WARPS  per-warp pop; one-hot or zero
- ibuf_pc  in  NUM_WARPS*ARCH_LEN  per-warp PC, warp g at [ARCH_LEN*g +: ARCH_LEN]
- ibuf_raw  in  NUM_WARPS*INST_BITS  per-warp raw instruction, same packing
- ibuf_tmask  in  NUM_WARPS*NUM_LANES  per-warp thread mask, same packing
- warp_stall  in  NUM_WARPS  per-warp scoreboard/barrier stall; a stalled warp is never granted
- flush_valid  in  1  flush request
- flush_wid  in  WID_BITS  warp to flush
- issue_valid  out  1  output register holds an instruction
- issue_ready  in  1  downstream accepts
- issue_wid  out  WID_BITS  warp id of the held instruction
- issue_pc  out  ARCH_LEN  held PC
- issue_raw  out  INST_BITS  held raw instruction
- issue_tmask  out  NUM_LANES  held thread mask
- perf_issued  out  CNT_BITS  count of issue fires
- perf_backpressure  out  CNT_BITS  count of cycles with issue_valid && !issue_ready

## Operation
- fire = issue_valid && issue_ready.
- kill = flush_valid && issue_valid && !fire && issue_wid == flush_wid.
- load_en = !issue_valid || fire || kill.
- cand[g] = ibuf_valid[g] && !warp_stall[g] && !(flush_valid && flush_wid == g).
- Grant: when load_en and cand is nonzero, pick the first set bit of cand scanning upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_WARPS-1, 0, ...). Assert ibuf_ready for that warp only.
- On a grant: the output register captures the granted warp's wid/pc/raw/tmask, issue_valid <= 1, and rr_ptr <= (grant+1) mod NUM_WARPS. The wrap is explicit, so it is correct for non-power-of-two NUM_WARPS.
- load_en with no grant: issue_valid <= 0, payload held, rr_ptr unchanged.
- !load_en: all state held and ibuf_ready = 0.
- Flush drops only a held, unfired instruction of the matching warp, and blocks that warp from being granted in the same cycle. A held instruction that fires in the flush cycle is still issued.
- perf_issued increments on fire. perf_backpressure increments when issue_valid && !issue_ready. Both wrap modulo 2^CNT_BITS.
- Upstream rule: ibuf_valid must not depend on ibuf_ready. A warp's head is popped only on ibuf_valid && ibuf_ready.

## Timing
- Reset values: issue_valid=0, issue_wid/pc/raw/tmask=0, rr_ptr=0, both counters=0. ibuf_ready=0 while reset is high. Reset mid-operation discards any held instruction without a fire.
- Latency: 1 cycle from the buffer pop edge to issue_valid high. Throughput: 1 instruction/cycle under continuous issue_ready.
- Combinational paths: issue_ready, flush_*, ibuf_valid and warp_stall to ibuf_ready. There are no combinational input-to-issue_* paths; issue_* outputs are registered.
- Back-to-back grants to the same warp are permitted only when no other candidate exists at or after the advanced pointer.
- issue_* is stable while issue_valid && !issue_ready, unless a kill occurs.

## Structure
- Package warp_issue_pkg holds the wid type (logic [WID_BITS-1:0]) and a packed issue-payload struct {wid, pc, raw, tmask} sized by package-level constants matching the parameter defaults.
- Sub-module rr_pick: parameterized round-robin priority picker; inputs req[NUM_WARPS] and ptr; outputs a one-hot grant, a binary index and any.
- The top level holds the output register, rr_ptr, flush/kill logic and counters.

## Test plan
- All 8 warps valid, issue_ready=1, no stalls -> issue_wid sequence 0,1,...,7,0; one fire per cycle; perf_issued=16 after 16 fires.
- Only warps 2 and 5 valid, rr_ptr=3 -> warp 5 granted first, then 2, then 5; warp_stall[5]=1 -> only 2 is issued.
- Hold issue_ready=0 for 4 cycles with an instruction held -> ibuf_ready=0, issue_* stable, perf_backpressure=4; raise issue_ready -> fire, and the next grant loads in the same cycle.
- Warp 3 held, issue_ready=0, flush_valid=1, flush_wid=3, warp 3 also valid -> held instruction dropped, warp 3 not granted, another candidate loaded; with issue_ready=1 in the same cycle -> warp 3 still issues.
- NUM_WARPS=6: valid only on warps 5 and 0 -> grants alternate 5,0,5, and rr_ptr never exceeds 5.
- Assert reset while issue_valid=1 -> next cycle issue_valid=0, counters=0, rr_ptr=0, no fire counted.

Source files
------------

// File: rtl/warp_issue_pkg.sv
// Shared types for the warp issue arbiter: warp-id type, issue payload struct
// and the default sizing constants that match the top-level parameter defaults.
package warp_issue_pkg;
  localparam int NUM_WARPS_D = 8;
  localparam int ARCH_LEN_D  = 32;
  localparam int INST_BITS_D = 64;
  localparam int NUM_LANES_D = 16;
  localparam int CNT_BITS_D  = 32;
  localparam int WID_BITS_D  = $clog2(NUM_WARPS_D);

  typedef logic [WID_BITS_D-1:0] wid_t;

  typedef struct packed {
    wid_t                   wid;
    logic [ARCH_LEN_D-1:0]  pc;
    logic [INST_BITS_D-1:0] raw;
    logic [NUM_LANES_D-1:0] tmask;
  } issue_t;
endpackage

// File: rtl/warp_issue_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping at N
// (explicit wrap so non-power-of-two N works).
module rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  int          w_j;
  logic [W-1:0] w_jw;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    w_j   = 0;
    w_jw  = '0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      w_jw = W'(w_j);
      if (!any && req[w_jw]) begin
        any         = 1'b1;
        grant[w_jw] = 1'b1;
        idx         = w_jw;
      end
    end
  end
endmodule

// File: rtl/warp_issue_arbiter.sv
// Round-robin issue scheduler: pops one ready warp head per cycle into a
// one-entry output register, with per-warp flush and perf counters.
module warp_issue_arbiter
  import warp_issue_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_D,
  parameter int ARCH_LEN  = ARCH_LEN_D,
  parameter int INST_BITS = INST_BITS_D,
  parameter int NUM_LANES = NUM_LANES_D,
  parameter int CNT_BITS  = CNT_BITS_D,
  localparam int WID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_WARPS-1:0]           ibuf_valid,
  output logic [NUM_WARPS-1:0]           ibuf_ready,
  input  logic [NUM_WARPS*ARCH_LEN-1:0]  ibuf_pc,
  input  logic [NUM_WARPS*INST_BITS-1:0] ibuf_raw,
  input  logic [NUM_WARPS*NUM_LANES-1:0] ibuf_tmask,
  input  logic [NUM_WARPS-1:0]           warp_stall,
  input  logic                           flush_valid,
  input  logic [WID_BITS-1:0]            flush_wid,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [WID_BITS-1:0]            issue_wid,
  output logic [ARCH_LEN-1:0]            issue_pc,
  output logic [INST_BITS-1:0]           issue_raw,
  output logic [NUM_LANES-1:0]           issue_tmask,
  output logic [CNT_BITS-1:0]            perf_issued,
  output logic [CNT_BITS-1:0]            perf_backpressure
);
  logic                 r_valid;
  logic [WID_BITS-1:0]  r_wid, r_rr_ptr;
  logic [ARCH_LEN-1:0]  r_pc;
  logic [INST_BITS-1:0] r_raw;
  logic [NUM_LANES-1:0] r_tmask;
  logic [CNT_BITS-1:0]  r_issued, r_bp;

  logic                 w_fire, w_kill, w_load, w_any;
  logic [NUM_WARPS-1:0] w_cand, w_grant;
  logic [WID_BITS-1:0]  w_idx, w_nxt;

  assign w_fire = r_valid && issue_ready;
  assign w_kill = flush_valid && r_valid && !w_fire && (r_wid == flush_wid);
  assign w_load = !r_valid || w_fire || w_kill;

  // A warp being flushed this cycle is masked so its stale head is not issued.
  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_cand
    assign w_cand[g] = ibuf_valid[g] && !warp_stall[g] &&
                       !(flush_valid && flush_wid == WID_BITS'(g));
  end

  rr_pick #(.N(NUM_WARPS), .W(WID_BITS)) u_pick (
    .req   (w_cand),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  assign w_nxt      = (w_idx == WID_BITS'(NUM_WARPS-1)) ? '0 : w_idx + 1'b1;
  assign ibuf_ready = (w_load && !reset) ? w_grant : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_wid    <= '0;
      r_pc     <= '0;
      r_raw    <= '0;
      r_tmask  <= '0;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_wid    <= w_idx;
        r_pc     <= ibuf_pc[ARCH_LEN*w_idx +: ARCH_LEN];
        r_raw    <= ibuf_raw[INST_BITS*w_idx +: INST_BITS];
        r_tmask  <= ibuf_tmask[NUM_LANES*w_idx +: NUM_LANES];
        r_rr_ptr <= w_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_issued <= '0;
      r_bp     <= '0;
    end else begin
      if (w_fire) r_issued <= r_issued + 1'b1;
      if (r_valid && !issue_ready) r_bp <= r_bp + 1'b1;
    end
  end

  assign issue_valid       = r_valid;
  assign issue_wid         = r_wid;
  assign issue_pc          = r_pc;
  assign issue_raw         = r_raw;
  assign issue_tmask       = r_tmask;
  assign perf_issued       = r_issued;
  assign perf_backpressure = r_bp;
endmodule
